// File: rtl/clk_div_prog.sv
// Programmable integer clock divider, ratio 2..2^W-1, near-50% duty.
// Ratio changes take effect only at period boundaries; 0/1 or !en bypass.
module clk_div_prog #(
  parameter int RATIO_WIDTH = 8
) (
  input  logic                   i_ref_clk,
  input  logic                   i_rst_n,
  input  logic                   i_clk_en,
  input  logic [RATIO_WIDTH-1:0] i_div_ratio,
  output logic                   o_div_clk,
  output logic                   o_tick,
  output logic                   o_ratio_upd
);

  localparam int W = RATIO_WIDTH;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e         state_q;
  logic [W-1:0]   ratio_q;
  logic [W-1:0]   cnt_q;
  logic [W-1:0]   cnt_d;
  logic [W-1:0]   hi_len;
  logic           div_q;
  logic           tick_q;
  logic           upd_q;
  logic           ratio_ok;
  logic           at_end;

  assign ratio_ok = i_div_ratio >= W'(2);
  assign hi_len   = ratio_q - (ratio_q >> 1);
  assign cnt_d    = cnt_q + W'(1);
  assign at_end   = cnt_q == ratio_q - W'(1);

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ratio_q <= '0;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      tick_q  <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ratio_q <= i_div_ratio;
          cnt_q   <= '0;
          div_q   <= 1'b0;
          tick_q  <= 1'b0;
          upd_q   <= 1'b0;
          if (i_clk_en && ratio_ok) begin
            state_q <= RUN;
            div_q   <= 1'b1;
            tick_q  <= 1'b1;
          end
        end
        RUN: begin
          if (!i_clk_en) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            tick_q  <= 1'b0;
            upd_q   <= 1'b0;
          end else if (at_end) begin
            if (!ratio_ok) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              div_q   <= 1'b0;
              tick_q  <= 1'b0;
              upd_q   <= 1'b0;
            end else begin
              ratio_q <= i_div_ratio;
              cnt_q   <= '0;
              div_q   <= 1'b1;
              tick_q  <= 1'b1;
              upd_q   <= i_div_ratio != ratio_q;
            end
          end else begin
            // cnt_d never exceeds ratio_q-1 here, so no wrap
            cnt_q  <= cnt_d;
            div_q  <= cnt_d < hi_len;
            tick_q <= 1'b0;
            upd_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_div_clk   = (state_q == RUN) ? div_q : i_ref_clk;
  assign o_tick      = tick_q;
  assign o_ratio_upd = upd_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Randomized bench for clk_div_prog against a period-queue reference model.
// Each started period is expanded into its per-cycle expected outputs.
module tb_clk_div_prog;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [W-1:0] ratio;
  logic         div_clk;
  logic         tick;
  logic         upd;

  int n_tests = 0;
  int n_fail  = 0;
  int n_upd   = 0;

  clk_div_prog #(.RATIO_WIDTH(W)) dut (
    .i_ref_clk  (clk),
    .i_rst_n    (rst_n),
    .i_clk_en   (en),
    .i_div_ratio(ratio),
    .o_div_clk  (div_clk),
    .o_tick     (tick),
    .o_ratio_upd(upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit div;
    bit tick;
    bit upd;
  } ent_t;

  ent_t q[$];
  bit   running = 0;
  int   cur     = 0;
  int   per_len = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int pos();
    return per_len - q.size();
  endfunction

  task automatic push_period(input int n, input bit chg);
    ent_t e;
    per_len = n;
    for (int k = 0; k < n; k++) begin
      e.div  = (2 * k < n);
      e.tick = (k == 0);
      e.upd  = (k == 0) && chg;
      q.push_back(e);
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      running = 0;
      q.delete();
      cur = 0;
    end else if (!running) begin
      if (en && ratio >= 2) begin
        push_period(ratio, 1'b0);
        running = 1;
      end
      cur = ratio;
    end else if (!en) begin
      running = 0;
      q.delete();
    end else begin
      void'(q.pop_front());
      if (q.size() == 0) begin
        if (ratio < 2) begin
          running = 0;
        end else begin
          push_period(ratio, int'(ratio) != cur);
          cur = ratio;
        end
      end
    end
  endtask

  task automatic edge_half();
    @(posedge clk);
    model_step();
    #1;
    if (upd === 1'b1) n_upd++;
    check("div_hi", div_clk, running ? q[0].div : 1'b1);
    check("tick", tick, running ? q[0].tick : 1'b0);
    check("upd", upd, running ? q[0].upd : 1'b0);
  endtask

  task automatic neg_half();
    @(negedge clk);
    check("div_lo", div_clk, running ? q[0].div : 1'b0);
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      edge_half();
      neg_half();
    end
  endtask

  task automatic wait_pos(input int k);
    int lim;
    lim = 0;
    while (!(running && pos() == k) && lim < 600) begin
      cyc();
      lim++;
    end
    if (lim >= 600) check("wait_pos", pos(), k);
  endtask

  function automatic logic [W-1:0] pick_ratio();
    int r;
    r = $urandom_range(0, 19);
    if (r < 2) return W'($urandom_range(0, 1));
    if (r < 18) return W'($urandom_range(2, 9));
    return W'($urandom_range(250, 255));
  endfunction

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    ratio = 8'd4;
    cyc(3);
    rst_n = 1'b1;
    cyc(20);

    en = 1'b1;
    n_upd = 0;
    cyc(12);
    check("upd_none_r4", n_upd, 0);
    ratio = 8'd5;
    cyc(15);
    ratio = 8'd2;
    cyc(8);
    ratio = 8'd3;
    cyc(9);

    ratio = 8'd4;
    wait_pos(0);
    cyc(4);
    wait_pos(1);
    n_upd = 0;
    ratio = 8'd6;
    cyc(20);
    check("upd_once_r6", n_upd, 1);

    wait_pos(2);
    en = 1'b0;
    cyc(5);
    en = 1'b1;
    cyc(1);
    check("reen_tick", tick, 1'b1);
    wait_pos(2);
    edge_half();
    #2;
    rst_n = 1'b0;
    #1;
    model_step();
    check("rst_div", div_clk, 1'b1);
    check("rst_tick", tick, 1'b0);
    check("rst_upd", upd, 1'b0);
    neg_half();
    cyc(2);
    rst_n = 1'b1;
    cyc(6);

    en    = 1'b0;
    ratio = 8'd255;
    cyc(2);
    en = 1'b1;
    cyc(300);
    ratio = 8'd1;
    cyc(300);
    check("bypass_end", running, 1'b0);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) ratio = pick_ratio();
      if ($urandom_range(0, 59) == 0) en = ~en;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Programmable integer clock divider with an N-bit ratio and a registered divided clock. Odd and even ratios produce near-50 % duty. Ratio changes are adopted glitch-free at period boundaries. Outputs include a period-start tick and a ratio-update strobe. The block sits in the clock-generation area and feeds peripheral clocks (UART, SPI, timers) from `i_ref_clk`. Ratios 0 and 1, or a deasserted enable, select bypass.

## Interface
- `RATIO_WIDTH`, default 8: width of the divide ratio. Valid ratios are 2 .. 2^RATIO_WIDTH-1.
- `i_ref_clk`, in, 1: reference clock. All state updates on its rising edge.
- `i_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_clk_en`, in, 1: divider enable.
- `i_div_ratio`, in, RATIO_WIDTH: requested divide ratio N.
- `o_div_clk`, out, 1: divided clock. Equals `i_ref_clk` in bypass.
- `o_tick`, out, 1: one-ref-cycle pulse during the first ref cycle of each divided period.
- `o_ratio_upd`, out, 1: one-ref-cycle pulse when a different ratio is adopted at a boundary.

## Operation
- Internal state:
  - `r_ratio` (RATIO_WIDTH): active ratio.
  - `cnt` (RATIO_WIDTH): ref-cycle index within the period.
  - `div_q`: registered divided clock.
  - FSM with states IDLE and RUN.
- High-phase length: H = r_ratio - (r_ratio >> 1), computed at RATIO_WIDTH with no overflow.
  - Even N: H = N/2.
  - Odd N: H = (N+1)/2, so the high phase is one ref cycle longer than the low phase.
- Output mux: `o_div_clk` = `div_q` in RUN, `i_ref_clk` in IDLE. This is the only combinational path to an output.
- IDLE:
  - `r_ratio` <= `i_div_ratio` every cycle.
  - `cnt` = 0, `div_q` = 0, `o_tick` = 0, `o_ratio_upd` = 0.
  - Transition to RUN when `i_clk_en`=1 and `i_div_ratio` >= 2. On that edge: load `r_ratio`, `cnt`<=0, `div_q`<=1, `o_tick`<=1.
- RUN, in priority order:
  1. `i_clk_en`=0: go to IDLE. `cnt`<=0, `div_q`<=0, `o_tick`<=0. Any partial period is aborted.
  2. Boundary (`cnt` == `r_ratio`-1):
     - If `i_div_ratio` < 2: go to IDLE.
     - Otherwise: `r_ratio`<=`i_div_ratio`, `cnt`<=0, `div_q`<=1, `o_tick`<=1. Set `o_ratio_upd`<=1 iff `i_div_ratio` != old `r_ratio`.
  3. Otherwise: `cnt`<=`cnt`+1, `div_q`<=(`cnt`+1 < H), `o_tick`<=0, `o_ratio_upd`<=0.
- `i_div_ratio` is ignored in RUN except at the boundary. A change mid-period never shortens or stretches the current period.
- Each divided period is exactly `r_ratio` ref cycles: H high, then `r_ratio`-H low.

## Timing
- Reset (asynchronous assert, synchronous release by the clock edge):
  - State = IDLE, `r_ratio`=0, `cnt`=0, `div_q`=0.
  - `o_tick`=0, `o_ratio_upd`=0.
  - `o_div_clk` follows `i_ref_clk` (bypass).
- Reset asserted mid-operation: immediate return to the reset values. The first period after release starts fresh.
- Start latency: the first `div_q` rising edge is at the first `i_ref_clk` edge where `i_clk_en`=1 and `i_div_ratio`>=2 are sampled in IDLE.
- Enable removal: `o_div_clk` switches to bypass one ref edge after `i_clk_en`=0 is sampled.
- `o_tick` and `div_q` rise on the same edge. `o_tick` is high only for ref cycle `cnt`=0.
- `o_ratio_upd` is coincident with `o_tick` of the first period at the new ratio.
- Ratio change at the boundary edge itself: the sampled value is used for the next period.
- Max ratio (2^RATIO_WIDTH-1): `cnt` reaches 2^RATIO_WIDTH-2 and never wraps past it.

## Test plan
- Reset with `i_clk_en`=0, ratio=4 -> `o_div_clk` mirrors `i_ref_clk`; `o_tick`=0 and `o_ratio_upd`=0 for 20 cycles.
- `i_clk_en`=1, ratio=4 -> `div_q` pattern 1,1,0,0 repeating; `o_tick` every 4th cycle starting on the enable edge; `o_ratio_upd` never pulses.
- ratio=5 -> pattern 1,1,1,0,0; ratio=2 -> 1,0; ratio=3 -> 1,1,0.
- Running at 4, change to 6 at `cnt`=1 -> current period still 4 cycles. Next periods are 1,1,1,0,0,0. `o_ratio_upd` pulses once with the first `o_tick` at ratio 6.
- Running at 6, drop `i_clk_en` at `cnt`=2 -> bypass from the next edge. Re-enable -> fresh period starting high with `o_tick`. Assert `i_rst_n`=0 at `cnt`=3 -> all registers clear immediately.
- RATIO_WIDTH=8, ratio=255 -> 128 high, 127 low, period 255. Then set ratio=1 -> after the current period completes, bypass with no runt pulse.
